// File: rtl/uart_frame_decoder.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_decoder
// Purpose  : Assembles UART bytes into SYNC/LEN/payload/CHK frames, buffers the
//            payload and releases it on a valid/ready stream once CHK passes.
// Revision : 1.0 - initial release
// ============================================================================
module uart_frame_decoder #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       overrun,
  output logic       busy
);

  localparam int             AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int             CW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]  TMO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]     MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHECK   = 3'd3,
    ST_SEND    = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          s1_q, s2_q, s3_q;
  logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [7:0]    acc_q, acc_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    wptr_q, wptr_d;
  logic [7:0]    rptr_q, rptr_d;
  logic [7:0]    out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic          frame_ok_q, frame_ok_d;
  logic          frame_err_q, frame_err_d;
  logic [1:0]    err_code_q, err_code_d;
  logic          overrun_q, overrun_d;
  logic          busy_q, busy_d;

  logic [7:0]    buf_mem [MAX_LEN];
  logic          buf_we;
  logic          byte_evt;
  logic          in_frame;
  logic          tmo_hit;
  logic          xfer;
  logic [7:0]    rptr_inc;

  assign byte_evt = s2_q & ~s3_q;
  assign in_frame = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CHECK);
  assign tmo_hit  = in_frame && (tmo_cnt_q == TMO_LAST);
  assign xfer     = out_valid_q & out_ready;
  assign rptr_inc = rptr_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    tmo_cnt_d   = '0;
    acc_d       = acc_q;
    len_d       = len_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    overrun_d   = 1'b0;
    buf_we      = 1'b0;

    if (in_frame) begin
      tmo_cnt_d = byte_evt ? '0 : tmo_cnt_q + 1'b1;
    end

    // An expiring timeout swallows any byte landing in the same cycle.
    if (tmo_hit) begin
      frame_err_d = 1'b1;
      err_code_d  = 2'd3;
      tmo_cnt_d   = '0;
      state_d     = ST_HUNT;
    end else begin
      case (state_q)
        ST_HUNT: begin
          if (byte_evt && (rx_data == SYNC_BYTE)) begin
            acc_d   = 8'h00;
            state_d = ST_LEN;
          end
        end
        ST_LEN: begin
          if (byte_evt) begin
            if ((rx_data == 8'h00) || (rx_data > MAX_LEN_B)) begin
              frame_err_d = 1'b1;
              err_code_d  = 2'd1;
              state_d     = ST_HUNT;
            end else begin
              len_d   = rx_data;
              acc_d   = rx_data;
              wptr_d  = 8'h00;
              state_d = ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          if (byte_evt) begin
            buf_we = 1'b1;
            acc_d  = acc_q + rx_data;
            wptr_d = wptr_q + 8'd1;
            if ((wptr_q + 8'd1) == len_q) begin
              state_d = ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          if (byte_evt) begin
            if ((acc_q + rx_data) == 8'h00) begin
              frame_ok_d  = 1'b1;
              rptr_d      = 8'h00;
              out_valid_d = 1'b1;
              out_data_d  = buf_mem[AW'(0)];
              out_last_d  = (len_q == 8'd1);
              state_d     = ST_SEND;
            end else begin
              frame_err_d = 1'b1;
              err_code_d  = 2'd2;
              state_d     = ST_HUNT;
            end
          end
        end
        ST_SEND: begin
          overrun_d = byte_evt;
          if (xfer) begin
            if (out_last_q) begin
              out_valid_d = 1'b0;
              out_last_d  = 1'b0;
              out_data_d  = 8'h00;
              state_d     = ST_HUNT;
            end else begin
              // Preload the next byte so out_data/out_last stay registered.
              rptr_d     = rptr_inc;
              out_data_d = buf_mem[rptr_inc[AW-1:0]];
              out_last_d = (rptr_inc == (len_q - 8'd1));
            end
          end
        end
        default: begin
          state_d = ST_HUNT;
        end
      endcase
    end

    busy_d = (state_d != ST_HUNT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_HUNT;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      tmo_cnt_q   <= '0;
      acc_q       <= 8'h00;
      len_q       <= 8'h00;
      wptr_q      <= 8'h00;
      rptr_q      <= 8'h00;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= 2'd0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      s1_q        <= rx_done;
      s2_q        <= s1_q;
      s3_q        <= s2_q;
      tmo_cnt_q   <= tmo_cnt_d;
      acc_q       <= acc_d;
      len_q       <= len_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  // Payload storage needs no reset; contents are only read after being written.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_mem[wptr_q[AW-1:0]] <= rx_data;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_frame_decoder
// Purpose  : Directed and randomized frames checked against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_frame_decoder;

  localparam int TO = 300;
  localparam int ML = 16;

  logic       clk       = 1'b0;
  logic       rst       = 1'b0;
  logic       rx_done   = 1'b0;
  logic [7:0] rx_data   = 8'h00;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       overrun;
  logic       busy;

  uart_frame_decoder #(
    .SYNC_BYTE      (8'hA5),
    .MAX_LEN        (ML),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_done   (rx_done),
    .rx_data   (rx_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_code  (err_code),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: collects transfers and pulse counts, checks stall stability.
  logic [8:0] got_q[$];
  int         ok_cnt  = 0;
  int         err_cnt = 0;
  int         ovr_cnt = 0;
  logic       hold_pend = 1'b0;
  logic [8:0] hold_v    = 9'h0;

  always @(negedge clk) begin
    if (rst) begin
      if (frame_ok)  ok_cnt++;
      if (frame_err) err_cnt++;
      if (overrun)   ovr_cnt++;
      if (frame_ok | frame_err) check("ok_err_exclusive", 32'(frame_ok & frame_err), 32'd0);
      if (hold_pend) check("stall_hold", {22'd0, out_valid, out_last, out_data}, {22'd0, 1'b1, hold_v});
      hold_pend = out_valid && !out_ready;
      hold_v    = {out_last, out_data};
      if (out_valid && out_ready) got_q.push_back({out_last, out_data});
    end else begin
      hold_pend = 1'b0;
    end
  end

  // Consumer: 0 always ready, 1 random, 2 never ready, 3 fixed pattern per valid cycle.
  int   rmode = 0;
  int   pidx  = 0;
  logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  always @(posedge clk) begin
    #1;
    case (rmode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      2: out_ready = 1'b0;
      default: begin
        if (out_valid && pidx < 6) begin
          out_ready = pat[pidx];
          pidx++;
        end else begin
          out_ready = 1'b1;
        end
      end
    endcase
  end

  // Frame-level reference: parses the byte list by the frame rules directly.
  logic [7:0] stim_q[$];
  logic [8:0] exp_q[$];
  int         exp_ok  = 0;
  int         exp_err = 0;
  logic [1:0] exp_code = 2'd0;

  function automatic void model();
    int i = 0;
    int len;
    int sum;
    exp_q.delete();
    exp_ok  = 0;
    exp_err = 0;
    while (i < stim_q.size()) begin
      if (stim_q[i] != 8'hA5) begin
        i++;
        continue;
      end
      if (i + 1 >= stim_q.size()) break;
      len = int'(stim_q[i+1]);
      if (len == 0 || len > ML) begin
        exp_err++;
        exp_code = 2'd1;
        i += 2;
        continue;
      end
      if (i + 2 + len >= stim_q.size()) break;
      sum = len + int'(stim_q[i+2+len]);
      for (int k = 0; k < len; k++) sum += int'(stim_q[i+2+k]);
      if (sum % 256 == 0) begin
        exp_ok++;
        for (int k = 0; k < len; k++) exp_q.push_back({(k == len - 1), stim_q[i+2+k]});
      end else begin
        exp_err++;
        exp_code = 2'd2;
      end
      i += len + 3;
    end
  endfunction

  task automatic send_byte(input logic [7:0] b, input int hold);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    repeat (hold) @(negedge clk);
    rx_done = 1'b0;
    rx_data = 8'($urandom);
    repeat (6) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic clear_counts();
    ok_cnt  = 0;
    err_cnt = 0;
    ovr_cnt = 0;
    got_q.delete();
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_ok"}, 32'(ok_cnt), 32'(exp_ok));
    check({tag, "_err"}, 32'(err_cnt), 32'(exp_err));
    check({tag, "_code"}, 32'(err_code), 32'(exp_code));
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      check({tag, "_byte"}, 32'(got_q[k]), 32'(exp_q[k]));
  endtask

  task automatic run_step(input string tag, input int hold);
    clear_counts();
    model();
    foreach (stim_q[i]) send_byte(stim_q[i], hold);
    wait_idle(tag);
    compare_stream(tag);
    check({tag, "_ovr"}, 32'(ovr_cnt), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_data"}, 32'(out_data), 32'd0);
    check({tag, "_last"}, 32'(out_last), 32'd0);
    check({tag, "_pulses"}, {29'd0, frame_ok, frame_err, overrun}, 32'd0);
    check({tag, "_code"}, 32'(err_code), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    int len;
    int sum;
    logic [7:0] b;

    // Reset state
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Good frame
    rmode = 0;
    stim_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    run_step("good", 8);

    // Backpressure pattern 1,0,0,1,0,1
    rmode = 3;
    pidx  = 0;
    run_step("bp", 8);
    rmode = 0;

    // Bad checksum followed by a good single-byte frame
    stim_q = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00};
    run_step("badchk", 8);
    stim_q = '{8'hA5, 8'h01, 8'h55, 8'hAA};
    run_step("after_badchk", 8);

    // Bad lengths with leading junk
    stim_q = '{8'h00, 8'hFF, 8'hA5, 8'h00};
    run_step("len0", 8);
    stim_q = '{8'hA5, 8'h11};
    run_step("len17", 8);

    // Timeout mid-payload
    clear_counts();
    send_byte(8'hA5, 8);
    send_byte(8'h02, 8);
    send_byte(8'h11, 8);
    repeat (TO / 2) @(negedge clk);
    check("tmo_busy_early", 32'(busy), 32'd1);
    check("tmo_err_early", 32'(err_cnt), 32'd0);
    n = 0;
    while (err_cnt == 0 && n < TO + 20) begin
      @(negedge clk);
      n++;
    end
    check("tmo_err", 32'(err_cnt), 32'd1);
    check("tmo_code", 32'(err_code), 32'd3);
    check("tmo_busy", 32'(busy), 32'd0);
    check("tmo_ok", 32'(ok_cnt), 32'd0);
    exp_code = 2'd3;

    // Overrun during a stalled SEND
    rmode = 2;
    repeat (3) @(negedge clk);
    clear_counts();
    stim_q = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'hFB};
    model();
    foreach (stim_q[i]) send_byte(stim_q[i], 8);
    check("ovr_valid", 32'(out_valid), 32'd1);
    check("ovr_data_before", 32'(out_data), 32'h01);
    send_byte(8'h77, 8);
    check("ovr_pulse", 32'(ovr_cnt), 32'd1);
    check("ovr_busy", 32'(busy), 32'd1);
    check("ovr_data_after", {23'd0, out_last, out_data}, {23'd0, 1'b0, 8'h01});
    rmode = 0;
    wait_idle("ovr");
    compare_stream("ovr");

    // Reset mid-payload (err_code is non-zero going in)
    clear_counts();
    send_byte(8'hA5, 8);
    send_byte(8'h04, 8);
    send_byte(8'h01, 8);
    send_byte(8'h02, 8);
    check("mid_busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all_zero("midrst");
    repeat (4) @(negedge clk);
    rst = 1'b1;
    exp_code = 2'd0;
    repeat (3) @(negedge clk);

    // Long rx_done levels must still yield one event per byte
    stim_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    run_step("long_rx", 150);

    // Randomized frames
    for (int f = 0; f < 25; f++) begin
      stim_q.delete();
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h5A;
        stim_q.push_back(b);
      end
      stim_q.push_back(8'hA5);
      len = int'($urandom_range(0, ML + 2));
      stim_q.push_back(8'(len));
      if (len >= 1 && len <= ML) begin
        sum = len;
        for (int k = 0; k < len; k++) begin
          b = 8'($urandom);
          stim_q.push_back(b);
          sum += int'(b);
        end
        b = 8'((256 - (sum % 256)) % 256);
        if ($urandom_range(0, 3) == 0) b = b + 8'($urandom_range(1, 255));
        stim_q.push_back(b);
      end
      rmode = int'($urandom_range(0, 1));
      run_step("rand", 8);
    end
    rmode = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
